fulladder_pipe: RTL
===================

Name: fulladder_pipe

Overview:
- Parametrised, pipelined successor of the 4-bit ripple adder. Supports WIDTH-bit add/subtract, split into SEG-bit ripple segments.
- One pipeline register stage per segment. The carry passes between stages through registers.
- Operand skew is handled internally. Throughput is one operation per clock.
- Valid/ready handshake on both sides. Used wherever a wide adder would otherwise break timing.

Parameters:
- WIDTH, 16, operand/result width in bits.
- SEG, 4, bits per pipeline segment. WIDTH % SEG must be 0, otherwise elaboration fails. NSTAGE = WIDTH/SEG.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands valid.
- in_ready  output  1  block accepts operands this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- ci  input  1  carry-in (add) / borrow-in (sub).
- sub  input  1  0 = add, 1 = subtract.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- so  output  WIDTH  sum/difference.
- co  output  1  raw carry-out of MSB segment.

Behaviour:
- Reset is asynchronous, active-low (rst_n = 0). All pipeline valids clear, all data registers clear. Outputs after reset: out_valid=0, so=0, co=0. in_ready=1 once rst_n is high.
- Arithmetic, per transaction:
  - add: {co,so} = a + b + ci.
  - sub: {co,so} = a + ~b + ~ci, i.e. a - b - ci. co=1 means no borrow.
  - Result is mod 2^WIDTH. Extra width is never dropped silently; co carries it.
- Pipeline:
  - Stage k (0..NSTAGE-1) adds segment k, using the carry registered by stage k-1. Stage 0 uses ci (or ~ci when sub=1).
  - b is inverted at entry when sub=1. The sub bit is not needed after entry.
  - Upper operand segments are carried forward (skewed) in registers. Lower result segments are delayed so that all of so appears together.
- Global advance: adv = !out_valid || out_ready.
  - When adv=1, every stage shifts one step and stage 0 captures the inputs, with its valid = in_valid.
  - When adv=0, every register holds.
- in_ready = adv (combinational from out_valid/out_ready). A transfer occurs when in_valid && in_ready.
- Latency: NSTAGE cycles from input transfer to out_valid=1, with no stall. NSTAGE=1 is legal (latency 1).
- Throughput: back-to-back inputs produce back-to-back outputs, one per clock, when out_ready is held at 1.
- Bubbles: in_valid=0 while adv=1 inserts a bubble. It reaches the output as out_valid=0.
- Stall: while out_valid=1 and out_ready=0:
  - so and co hold stable.
  - in_ready=0, and no input is captured.
  - No data is lost or duplicated.
- Simultaneous output accept and input accept in the same cycle is legal. Both complete.
- Reset mid-operation: all in-flight results are discarded. No partial result ever appears.
- Data registers do not need reset for correctness. so/co are still required to be 0 after reset.

Optional Feature:
- Macro: FULLADDER_PIPE_OVF_EN.
- Defined: adds output port ovf (1 bit, reset 0), pipelined alongside so/co.
  - ovf = signed two's-complement overflow of the operation: carry into MSB XOR carry out of MSB.
  - ovf is held during stall like so.
- Not defined: port ovf does not exist. No extra logic.

Test Plan (WIDTH=16, SEG=4):
- Carry ripple: a=0xFFFF, b=0x0001, ci=0, sub=0. Expect so=0x0000, co=1 exactly 4 cycles after the transfer, out_ready=1. With FULLADDER_PIPE_OVF_EN, ovf=0.
- Subtract with borrow: a=0x0005, b=0x0007, ci=0, sub=1 -> so=0xFFFE, co=0. Then a=0x8000, b=0x0001, sub=1 -> so=0x7FFF, co=1, ovf=1 (if enabled).
- Throughput: 8 back-to-back transfers (a=i, b=0x1000*i, ci=i&1), out_ready=1. Expect 8 consecutive out_valid cycles with correct results in order; in_ready stays 1.
- Backpressure: 3 results in flight, hold out_ready=0 for 5 cycles.
  - in_ready=0 and so/co stable throughout.
  - After release, results drain in order. No loss, no duplicates.
- Bubbles: in_valid pattern 1,0,1,0,1 -> out_valid pattern 1,0,1,0,1 with the same 4-cycle offset.
- Reset mid-flight: assert rst_n=0 for 1 cycle with 4 ops in flight.
  - Immediately out_valid=0, so=0, co=0.
  - No stale result appears afterwards. The next op completes in 4 cycles.

Source files
------------

// File: rtl/fulladder_pipe_if.sv
// Operand/result handshake bundle for fulladder_pipe.
// Carries the optional ovf signal when FULLADDER_PIPE_OVF_EN is defined.
interface fulladder_pipe_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             ci;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] so;
   logic             co;
`ifdef FULLADDER_PIPE_OVF_EN
   logic             ovf;

   modport master (
      output in_valid, a, b, ci, sub, out_ready,
      input  in_ready, out_valid, so, co, ovf
   );

   modport slave (
      input  in_valid, a, b, ci, sub, out_ready,
      output in_ready, out_valid, so, co, ovf
   );
`else
   modport master (
      output in_valid, a, b, ci, sub, out_ready,
      input  in_ready, out_valid, so, co
   );

   modport slave (
      input  in_valid, a, b, ci, sub, out_ready,
      output in_ready, out_valid, so, co
   );
`endif
endinterface

// File: rtl/fulladder_pipe.sv
// Pipelined WIDTH-bit add/subtract, one SEG-bit ripple segment per stage.
// Optional signed-overflow output enabled by FULLADDER_PIPE_OVF_EN.
module fulladder_pipe #(
   parameter int WIDTH = 16,
   parameter int SEG   = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   fulladder_pipe_if.slave    bus
);
   localparam int NSTAGE = WIDTH / SEG;

   if ((WIDTH % SEG) != 0) begin : g_bad_seg
      $error("fulladder_pipe: WIDTH must be a multiple of SEG");
   end

   // Stage k holds full-width operands (b already inverted for subtract),
   // the partial sum with segments 0..k filled in, and the carry out of segment k.
   logic [WIDTH-1:0]  a_q [NSTAGE];
   logic [WIDTH-1:0]  a_d [NSTAGE];
   logic [WIDTH-1:0]  b_q [NSTAGE];
   logic [WIDTH-1:0]  b_d [NSTAGE];
   logic [WIDTH-1:0]  s_q [NSTAGE];
   logic [WIDTH-1:0]  s_d [NSTAGE];
   logic [NSTAGE-1:0] c_q, c_d;
   logic [NSTAGE-1:0] v_q, v_d;

   logic              adv;
   logic [WIDTH-1:0]  b_in;
   logic [SEG:0]      seg_sum;

   always_comb begin
      adv     = !v_q[NSTAGE-1] || bus.out_ready;
      a_d     = a_q;
      b_d     = b_q;
      s_d     = s_q;
      c_d     = c_q;
      v_d     = v_q;
      b_in    = bus.sub ? ~bus.b : bus.b;
      seg_sum = '0;
      if (adv) begin
         seg_sum = {1'b0, bus.a[SEG-1:0]} + {1'b0, b_in[SEG-1:0]}
                 + {{SEG{1'b0}}, bus.ci ^ bus.sub};
         a_d[0]          = bus.a;
         b_d[0]          = b_in;
         s_d[0]          = '0;
         s_d[0][SEG-1:0] = seg_sum[SEG-1:0];
         c_d[0]          = seg_sum[SEG];
         v_d[0]          = bus.in_valid;
         for (int k = 1; k < NSTAGE; k++) begin
            seg_sum = {1'b0, a_q[k-1][k*SEG +: SEG]} + {1'b0, b_q[k-1][k*SEG +: SEG]}
                    + {{SEG{1'b0}}, c_q[k-1]};
            a_d[k]              = a_q[k-1];
            b_d[k]              = b_q[k-1];
            s_d[k]              = s_q[k-1];
            s_d[k][k*SEG +: SEG] = seg_sum[SEG-1:0];
            c_d[k]              = seg_sum[SEG];
            v_d[k]              = v_q[k-1];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < NSTAGE; k++) begin
            a_q[k] <= '0;
            b_q[k] <= '0;
            s_q[k] <= '0;
         end
         c_q <= '0;
         v_q <= '0;
      end else begin
         a_q <= a_d;
         b_q <= b_d;
         s_q <= s_d;
         c_q <= c_d;
         v_q <= v_d;
      end
   end

   assign bus.in_ready  = adv;
   assign bus.out_valid = v_q[NSTAGE-1];
   assign bus.so        = s_q[NSTAGE-1];
   assign bus.co        = c_q[NSTAGE-1];

`ifdef FULLADDER_PIPE_OVF_EN
   logic ovf_q, ovf_d;

   // Carry into the MSB is recovered from the MSB's own sum bit and operands.
   always_comb begin
      ovf_d = ovf_q;
      if (adv) begin
         ovf_d = a_d[NSTAGE-1][WIDTH-1] ^ b_d[NSTAGE-1][WIDTH-1]
               ^ s_d[NSTAGE-1][WIDTH-1] ^ c_d[NSTAGE-1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
      end
   end

   assign bus.ovf = ovf_q;
`endif

endmodule
